tx_crc_append: RTL and testbench
================================

Name: tx_crc_append

Overview:
- TX-path framing stage that serialises a byte stream LSB-first into a bit stream.
- Drives the crc_a block (start/sample/data) with every data bit, then captures crc_a's result and appends it, LSByte first and LSB-first within each byte.
- Sits between the frame byte source and the bit-level encoder/parity inserter.

Parameters:
- CRC_LATENCY, 1: cycles from crc_sample high until the crc input reflects that bit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  byte available
- in_ready  out  1  byte accepted when in_valid & in_ready
- in_data  in  8  data byte
- in_last  in  1  byte is the final data byte of the frame
- in_crc  in  1  sampled with the in_last byte: 1 = append CRC
- out_valid  out  1  bit available
- out_ready  in  1  bit consumed when out_valid & out_ready
- out_data  out  1  current bit
- out_last  out  1  current bit is the final bit of the frame
- out_err  out  1  one-cycle pulse on underrun abort
- crc_start  out  1  to crc_a: reset CRC to 16'h6363
- crc_sample  out  1  to crc_a: absorb crc_data
- crc_data  out  1  to crc_a: bit value
- crc  in  16  from crc_a: current CRC

Behaviour:
- Reset, synchronous, applied at any time including mid-frame: state IDLE, byte buffer empty, counters 0.
  - All outputs 0 except in_ready=1.
  - No crc_start is issued.
- One-entry byte buffer: in_ready = !buffer_full.
  - A byte accepted in IDLE goes straight to the shift register.
  - Later bytes wait in the buffer.
- FSM states: IDLE, DATA, CRC_WAIT, CRC.
- IDLE: on accept, load shift register, latch in_last and in_crc, go to DATA.
  - crc_start is registered, high exactly one cycle, the cycle after accept.
  - out_valid rises in that same cycle.
- DATA: out_data = shreg[0]; out_valid=1.
  - Each bit handshake: shift right, increment the 3-bit bit counter.
  - The following cycle: crc_sample=1 for one cycle, crc_data = the handshaken bit.
  - This keeps the first crc_sample at least one cycle after crc_start.
- End of a non-last byte (handshake with count==7):
  - If the buffer is full, load the next byte in the same cycle. out_valid stays high with no bubble.
  - If the buffer is empty (underrun): pulse out_err, deassert out_valid, go to IDLE.
- End of the last byte:
  - If the CRC flag is 0: out_last=1 during that final bit; on its handshake go to IDLE.
  - If the CRC flag is 1: go to CRC_WAIT with out_valid=0.
- CRC_WAIT: wait for the final crc_sample plus CRC_LATENCY cycles.
  - Then latch crc into a 16-bit shift register and go to CRC.
  - For CRC_LATENCY=1, out_valid is low for exactly 2 cycles after the final data-bit handshake.
- CRC: shift out crc[0] through crc[15], 4-bit counter.
  - CRC bits are NOT fed to crc_a (crc_sample stays 0).
  - out_last=1 on crc[15]; on its handshake go to IDLE.
- Backpressure: out_data, out_last and out_valid are held stable while out_valid & !out_ready.
- No bit is lost or duplicated under backpressure.
- Zero-length frames are not supported. A frame always starts with an accepted byte.
- in_crc is ignored on bytes other than the in_last byte.
- A byte may be accepted into the buffer in the same cycle the buffer drains.

Test Plan:
- {8'h00,8'h00}, in_crc=1, out_ready=1 → 16 zero bits, 2-cycle gap, then CRC 16'h1EA0 sent as A0 then 1E.
  - Bit stream 0,0,0,0,0,1,0,1, 0,1,1,1,1,0,0,0; out_last on the 32nd bit; 16 crc_sample pulses; exactly 1 crc_start.
- {8'h12,8'h34}, in_crc=1 → appended bytes 8'h26 then 8'hCF.
  - Feeding the whole 32-bit output back through crc_a yields crc 16'h0000.
- Single byte 8'hA5, in_crc=0 → bits 1,0,1,0,0,1,0,1; out_last on the 8th bit; 8 crc_sample pulses; back to IDLE with in_ready=1.
- 3-byte frame with random out_ready (≈50% duty) → bit sequence identical to the out_ready=1 run, and the CRC matches the reference model for random payloads of 1..10 bytes.
- Withhold the 2nd byte until after the 8th bit handshake → out_err pulses once, out_valid=0; the next frame starts cleanly with a new crc_start.
- Assert rst_n=0 for one cycle in the middle of CRC → next cycle all outputs 0 and in_ready=1; the next frame's CRC is correct.

Source files
------------

// File: rtl/tx_crc_append.sv
// ============================================================================
// tx_crc_append : LSB-first byte-to-bit serialiser that drives an external
//                 crc_a engine and appends its 16-bit result to the frame.
// Revision 1.0
// ============================================================================
`default_nettype none

module tx_crc_append #(
  parameter int CRC_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_crc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_data,
  output logic        out_last,
  output logic        out_err,
  output logic        crc_start,
  output logic        crc_sample,
  output logic        crc_data,
  input  logic [15:0] crc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_CRC  = 2'd3;

  localparam int          WW  = $clog2(CRC_LATENCY + 2);
  localparam logic [WW-1:0] LAT = WW'(CRC_LATENCY);

  logic [1:0]    state_q,    state_d;
  logic [7:0]    shreg_q,    shreg_d;
  logic [2:0]    bitcnt_q,   bitcnt_d;
  logic [15:0]   crcsh_q,    crcsh_d;
  logic [3:0]    crccnt_q,   crccnt_d;
  logic [WW-1:0] wait_q,     wait_d;
  logic          cur_last_q, cur_last_d;
  logic          cur_crc_q,  cur_crc_d;
  logic          buf_full_q, buf_full_d;
  logic [7:0]    buf_data_q, buf_data_d;
  logic          buf_last_q, buf_last_d;
  logic          buf_crc_q,  buf_crc_d;
  logic          start_q,    start_d;
  logic          sample_q,   sample_d;
  logic          sdata_q,    sdata_d;
  logic          err_q,      err_d;

  logic w_accept;
  logic w_in_data_st;
  logic w_in_crc_st;

  assign in_ready     = ~buf_full_q;
  assign w_accept     = in_valid & ~buf_full_q;
  assign w_in_data_st = (state_q == S_DATA);
  assign w_in_crc_st  = (state_q == S_CRC);

  // Outputs are gated by out_valid so idle cycles always present zeros.
  assign out_valid  = w_in_data_st | w_in_crc_st;
  assign out_data   = (w_in_data_st & shreg_q[0]) | (w_in_crc_st & crcsh_q[0]);
  assign out_last   = (w_in_data_st & cur_last_q & ~cur_crc_q & (bitcnt_q == 3'd7))
                    | (w_in_crc_st & (crccnt_q == 4'd15));
  assign out_err    = err_q;
  assign crc_start  = start_q;
  assign crc_sample = sample_q;
  assign crc_data   = sdata_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    crcsh_d    = crcsh_q;
    crccnt_d   = crccnt_q;
    wait_d     = wait_q;
    cur_last_d = cur_last_q;
    cur_crc_d  = cur_crc_q;
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    buf_crc_d  = buf_crc_q;
    start_d    = 1'b0;
    sample_d   = 1'b0;
    sdata_d    = 1'b0;
    err_d      = 1'b0;

    if (w_accept) begin
      buf_full_d = 1'b1;
      buf_data_d = in_data;
      buf_last_d = in_last;
      buf_crc_d  = in_crc;
    end

    case (state_q)
      S_IDLE: begin
        // A byte left in the buffer from the previous frame takes priority.
        if (buf_full_q) begin
          shreg_d    = buf_data_q;
          cur_last_d = buf_last_q;
          cur_crc_d  = buf_last_q & buf_crc_q;
          buf_full_d = 1'b0;
          bitcnt_d   = 3'd0;
          start_d    = 1'b1;
          state_d    = S_DATA;
        end else if (in_valid) begin
          shreg_d    = in_data;
          cur_last_d = in_last;
          cur_crc_d  = in_last & in_crc;
          buf_full_d = 1'b0;
          bitcnt_d   = 3'd0;
          start_d    = 1'b1;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (out_ready) begin
          sample_d = 1'b1;
          sdata_d  = shreg_q[0];
          shreg_d  = {1'b0, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            if (cur_last_q) begin
              wait_d  = '0;
              state_d = cur_crc_q ? S_WAIT : S_IDLE;
            end else if (buf_full_q) begin
              shreg_d    = buf_data_q;
              cur_last_d = buf_last_q;
              cur_crc_d  = buf_last_q & buf_crc_q;
              buf_full_d = 1'b0;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_WAIT: begin
        // Counting starts in the cycle the final crc_sample is issued.
        if (wait_q == LAT) begin
          crcsh_d  = crc;
          crccnt_d = 4'd0;
          state_d  = S_CRC;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: begin
        if (out_ready) begin
          crcsh_d  = {1'b0, crcsh_q[15:1]};
          crccnt_d = crccnt_q + 4'd1;
          if (crccnt_q == 4'd15) begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= 8'd0;
      bitcnt_q   <= 3'd0;
      crcsh_q    <= 16'd0;
      crccnt_q   <= 4'd0;
      wait_q     <= '0;
      cur_last_q <= 1'b0;
      cur_crc_q  <= 1'b0;
      buf_full_q <= 1'b0;
      buf_data_q <= 8'd0;
      buf_last_q <= 1'b0;
      buf_crc_q  <= 1'b0;
      start_q    <= 1'b0;
      sample_q   <= 1'b0;
      sdata_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      crcsh_q    <= crcsh_d;
      crccnt_q   <= crccnt_d;
      wait_q     <= wait_d;
      cur_last_q <= cur_last_d;
      cur_crc_q  <= cur_crc_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
      buf_crc_q  <= buf_crc_d;
      start_q    <= start_d;
      sample_q   <= sample_d;
      sdata_q    <= sdata_d;
      err_q      <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tx_crc_append.sv
// ============================================================================
// tb_tx_crc_append : directed bench for tx_crc_append with a crc_a model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_tx_crc_append;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        in_crc = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic        out_data;
  logic        out_last;
  logic        out_err;
  logic        crc_start;
  logic        crc_sample;
  logic        crc_data;
  logic [15:0] crc_m = 16'h0000;

  logic        rnd_en = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  tx_crc_append #(.CRC_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_crc(in_crc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err),
    .crc_start(crc_start), .crc_sample(crc_sample), .crc_data(crc_data),
    .crc(crc_m)
  );

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[0] ^ b;
    return fb ? ((c >> 1) ^ 16'h8408) : (c >> 1);
  endfunction

  // crc_a model: one cycle from crc_sample to updated crc
  always @(posedge clk) begin
    if (crc_start)       crc_m <= 16'h6363;
    else if (crc_sample) crc_m <= crc_step(crc_m, crc_data);
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic bq[$];
  logic lq[$];
  int   cq[$];
  int   cyc = 0;
  int   n_start = 0;
  int   n_sample = 0;
  int   n_oerr = 0;
  int   n_lastc = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        bq.push_back(out_data);
        lq.push_back(out_last);
        cq.push_back(cyc);
        if (out_last) n_lastc++;
      end
      if (crc_start)  n_start++;
      if (crc_sample) n_sample++;
      if (out_err)    n_oerr++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] grab(input int from, input int n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = bq[from + i];
    return r;
  endfunction

  function automatic logic [127:0] ref_vec(input byte_q_t d, input logic with_crc);
    logic [127:0] r;
    logic [15:0]  c;
    r = '0;
    c = 16'h6363;
    for (int i = 0; i < d.size(); i++) begin
      for (int k = 0; k < 8; k++) begin
        r[8*i + k] = d[i][k];
        c = crc_step(c, d[i][k]);
      end
    end
    if (with_crc) for (int k = 0; k < 16; k++) r[8*d.size() + k] = c[k];
    return r;
  endfunction

  task automatic push_byte(input logic [7:0] d, input logic l, input logic c);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = d; in_last = l; in_crc = c;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("push_timeout", 64'(t), 64'd0);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_crc = 1'b0;
  endtask

  task automatic do_frame(input byte_q_t d, input logic c,
                          output logic [127:0] v, output int nbits, output int lastidx,
                          output int nsamp, output int nstart, output int gap);
    int i0, s0, st0, l0, t;
    i0 = bq.size(); s0 = n_sample; st0 = n_start; l0 = n_lastc;
    for (int i = 0; i < d.size(); i++) push_byte(d[i], (i == d.size() - 1), c);
    t = 0;
    while (n_lastc == l0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("frame_done", 64'(n_lastc - l0), 64'd1);
    repeat (2) @(negedge clk);
    nbits   = bq.size() - i0;
    v       = grab(i0, nbits);
    lastidx = -1;
    for (int i = nbits - 1; i >= 0; i--) if (lq[i0 + i]) lastidx = i;
    nsamp   = n_sample - s0;
    nstart  = n_start - st0;
    gap     = (nbits > 16) ? cq[i0 + 16] - cq[i0 + 15] : 0;
  endtask

  logic [127:0] v, vfix, r;
  int nbits, lidx, nsamp, nst, gap, i0, e0, st0, t;
  byte_q_t fr;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_outs", 64'({out_valid, out_data, out_last, out_err, crc_start, crc_sample, crc_data}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", 64'({out_valid, out_err, crc_start, crc_sample, in_ready}), 64'd1);

    // {00,00} with CRC: 16 zero bits, then A0, 1E
    fr = '{8'h00, 8'h00};
    do_frame(fr, 1'b1, v, nbits, lidx, nsamp, nst, gap);
    check("z_bits", v[63:0], 64'h0000_0000_1EA0_0000);
    check("z_nbits", 64'(nbits), 64'd32);
    check("z_last", 64'(lidx), 64'd31);
    check("z_samples", 64'(nsamp), 64'd16);
    check("z_starts", 64'(nst), 64'd1);
    check("z_gap", 64'(gap), 64'd3);

    fr = '{8'h12, 8'h34};
    do_frame(fr, 1'b1, v, nbits, lidx, nsamp, nst, gap);
    check("k_bits", v[63:0], 64'h0000_0000_CF26_3412);
    r[15:0] = 16'h6363;
    for (int i = 0; i < 32; i++) r[15:0] = crc_step(r[15:0], v[i]);
    check("k_residue", 64'(r[15:0]), 64'd0);

    fr = '{8'hA5};
    do_frame(fr, 1'b0, v, nbits, lidx, nsamp, nst, gap);
    check("a5_bits", v[63:0], 64'h0000_0000_0000_00A5);
    check("a5_nbits", 64'(nbits), 64'd8);
    check("a5_last", 64'(lidx), 64'd7);
    check("a5_samples", 64'(nsamp), 64'd8);
    check("a5_idle", 64'({in_ready, out_valid}), 64'b10);

    // Same 3-byte frame with free-running and random out_ready
    fr = '{8'hDE, 8'hAD, 8'hBE};
    do_frame(fr, 1'b1, vfix, nbits, lidx, nsamp, nst, gap);
    check("f3_ref", vfix[63:0], ref_vec(fr, 1'b1)[63:0]);
    rnd_en = 1'b1;
    do_frame(fr, 1'b1, v, nbits, lidx, nsamp, nst, gap);
    check("f3_rnd_same", v[63:0], vfix[63:0]);
    check("f3_rnd_last", 64'(lidx), 64'd39);
    for (int f = 0; f < 4; f++) begin
      fr = {};
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) fr.push_back(8'($urandom));
      do_frame(fr, 1'b1, v, nbits, lidx, nsamp, nst, gap);
      r = ref_vec(fr, 1'b1);
      check("rnd_nbits", 64'(nbits), 64'(8 * fr.size() + 16));
      check("rnd_bitdiff", 64'($countones(v ^ r)), 64'd0);
    end
    rnd_en = 1'b0;
    repeat (3) @(negedge clk);

    // Underrun: second byte never arrives
    i0 = bq.size(); e0 = n_oerr; st0 = n_start;
    push_byte(8'h5A, 1'b0, 1'b0);
    t = 0;
    while (bq.size() < i0 + 8 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("ur_bits", 64'(grab(i0, bq.size() - i0)), 64'h5A);
    check("ur_err", 64'(n_oerr - e0), 64'd1);
    check("ur_valid", 64'(out_valid), 64'd0);
    fr = '{8'h00, 8'h00};
    do_frame(fr, 1'b1, v, nbits, lidx, nsamp, nst, gap);
    check("ur_next_bits", v[63:0], 64'h0000_0000_1EA0_0000);
    check("ur_next_start", 64'(nst), 64'd1);

    // Reset while the CRC is being shifted out
    i0 = bq.size();
    push_byte(8'h12, 1'b0, 1'b0);
    push_byte(8'h34, 1'b1, 1'b1);
    t = 0;
    while (bq.size() < i0 + 20 && t < 500) begin
      @(negedge clk);
      t++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_outs", 64'({out_valid, out_data, out_last, out_err, crc_start, crc_sample, crc_data}), 64'd0);
    check("mr_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    fr = '{8'h12, 8'h34};
    do_frame(fr, 1'b1, v, nbits, lidx, nsamp, nst, gap);
    check("mr_next_bits", v[63:0], 64'h0000_0000_CF26_3412);
    check("mr_next_start", 64'(nst), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
